// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding decode through a small buffer.
// Issues word reads, tracks in-flight requests and drops stale data on redirect.
//
// Ports:
//   clk, rst              clock, async active-low reset
//   imem_req/addr         fetch request and its address (fetch_pc)
//   imem_gnt              memory accepted the request
//   imem_rvalid/rdata     in-order read response
//   redirect/redirect_pc  taken branch/jump and its target
//   id_ready              decode accepts the head entry
//   id_valid              head entry present
//   instruction           head word, NOP when empty
//   out_pc_value          head PC, 0 when empty
module instruction_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] out_pc_value
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     word;
  } ent_t;

  logic [XLEN-1:0] fetch_pc;
  ent_t            q_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [AW-1:0]   q_rd, q_wr;
  logic [AW-1:0]   p_rd, p_wr;
  logic [CW-1:0]   q_cnt;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop;
  logic            run;

  logic            grant;
  logic            rsp;
  logic            rsp_keep;
  logic            pop;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] target;

  // run holds off the first request until one edge after reset release
  always_comb begin
    in_use       = {1'b0, q_cnt} + {1'b0, outst};
    imem_req     = run && !redirect && (in_use < LIMIT);
    grant        = imem_req && imem_gnt;
    rsp          = imem_rvalid && (outst != '0);
    rsp_keep     = rsp && (drop == '0);
    id_valid     = (q_cnt != '0);
    pop          = id_valid && id_ready;
    instruction  = id_valid ? q_mem[q_rd].word : NOP;
    out_pc_value = id_valid ? q_mem[q_rd].pc : '0;
    target       = redirect_pc & ~XLEN'(3);
  end

  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      q_rd     <= '0;
      q_wr     <= '0;
      p_rd     <= '0;
      p_wr     <= '0;
      q_cnt    <= '0;
      outst    <= '0;
      drop     <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        q_rd     <= '0;
        q_wr     <= '0;
        p_rd     <= '0;
        p_wr     <= '0;
        q_cnt    <= '0;
        fetch_pc <= target;
        outst    <= outst - CW'(rsp);
        drop     <= outst - CW'(rsp);
      end else begin
        if (grant) begin
          p_wr     <= p_wr + 1'b1;
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (rsp_keep) begin
          q_wr <= q_wr + 1'b1;
          p_rd <= p_rd + 1'b1;
        end
        if (pop) begin
          q_rd <= q_rd + 1'b1;
        end
        q_cnt <= q_cnt + CW'(rsp_keep) - CW'(pop);
        outst <= outst + CW'(grant) - CW'(rsp);
        if (rsp && (drop != '0)) begin
          drop <= drop - 1'b1;
        end
      end
    end
  end

  // storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (!redirect && grant) begin
      pc_mem[p_wr] <= fetch_pc;
    end
    if (!redirect && rsp_keep) begin
      q_mem[q_wr] <= {pc_mem[p_rd], imem_rdata};
    end
  end

endmodule
